// File: rtl/aes_req_sched.sv
// Round-robin front end that shares one AES core and one key ROM between NUM_REQ requesters.
// Key expansion is skipped when the granted key address matches the last expanded key.
module aes_req_sched #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned AES_LEN    = 128,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned ID_WIDTH   = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_key_addr,
  input  logic [NUM_REQ*AES_LEN-1:0]    req_block,
  output logic                          rom_en,
  output logic [ADDR_WIDTH-1:0]         rom_addr,
  output logic                          core_init,
  output logic                          core_next,
  output logic [AES_LEN-1:0]            core_block,
  input  logic                          core_ready,
  input  logic                          core_result_valid,
  input  logic [AES_LEN-1:0]            core_result,
  output logic                          rsp_valid,
  output logic [ID_WIDTH-1:0]           rsp_id,
  output logic [AES_LEN-1:0]            rsp_data,
  input  logic                          rsp_ready
);

  typedef enum logic [2:0] {
    StIdle, StKeyRd, StInit, StWaitKey, StNext, StWaitBlk, StResp
  } state_e;

  state_e                state_q, state_d;
  logic [ID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
  logic                  key_cached_q, key_cached_d;
  logic [ADDR_WIDTH-1:0] cached_addr_q, cached_addr_d;
  logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
  logic [ID_WIDTH-1:0]   cur_id_q, cur_id_d;
  logic [AES_LEN-1:0]    block_q, block_d;
  logic                  rom_en_q, rom_en_d;
  logic                  core_init_q, core_init_d;
  logic                  core_next_q, core_next_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [ID_WIDTH-1:0]   rsp_id_q, rsp_id_d;
  logic [AES_LEN-1:0]    rsp_data_q, rsp_data_d;

  logic                  grant_found;
  logic [ID_WIDTH-1:0]   grant_idx;

  logic [ADDR_WIDTH-1:0] key_addr_arr [NUM_REQ];
  logic [AES_LEN-1:0]    block_arr    [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign key_addr_arr[i] = req_key_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign block_arr[i]    = req_block[i*AES_LEN +: AES_LEN];
  end

  function automatic logic [ID_WIDTH-1:0] wrap_add(input logic [ID_WIDTH-1:0] base,
                                                   input int unsigned off);
    int unsigned sum;
    sum = (32'(base) + off) % NUM_REQ;
    return ID_WIDTH'(sum);
  endfunction

  // First pending requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!grant_found && req_valid[wrap_add(rr_ptr_q, k)]) begin
        grant_found = 1'b1;
        grant_idx   = wrap_add(rr_ptr_q, k);
      end
    end
  end

  // Accept pulse is only combinational output; held low while reset is asserted.
  always_comb begin
    req_ready = '0;
    if (state_q == StIdle && grant_found && !rst) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    key_cached_d  = key_cached_q;
    cached_addr_d = cached_addr_q;
    cur_addr_d    = cur_addr_q;
    cur_id_d      = cur_id_q;
    block_d       = block_q;
    rom_en_d      = 1'b0;
    core_init_d   = 1'b0;
    core_next_d   = 1'b0;
    rsp_valid_d   = rsp_valid_q;
    rsp_id_d      = rsp_id_q;
    rsp_data_d    = rsp_data_q;

    unique case (state_q)
      StIdle: begin
        if (grant_found) begin
          block_d    = block_arr[grant_idx];
          cur_addr_d = key_addr_arr[grant_idx];
          cur_id_d   = grant_idx;
          rr_ptr_d   = wrap_add(grant_idx, 1);
          if (key_cached_q && key_addr_arr[grant_idx] == cached_addr_q) begin
            state_d     = StNext;
            core_next_d = 1'b1;
          end else begin
            state_d  = StKeyRd;
            rom_en_d = 1'b1;
          end
        end
      end
      StKeyRd: begin
        state_d     = StInit;
        core_init_d = 1'b1;
      end
      StInit: begin
        key_cached_d = 1'b0;
        state_d      = StWaitKey;
      end
      StWaitKey: begin
        if (core_ready) begin
          key_cached_d  = 1'b1;
          cached_addr_d = cur_addr_q;
          state_d       = StNext;
          core_next_d   = 1'b1;
        end
      end
      StNext: begin
        state_d = StWaitBlk;
      end
      StWaitBlk: begin
        if (core_ready && core_result_valid) begin
          rsp_valid_d = 1'b1;
          rsp_id_d    = cur_id_q;
          rsp_data_d  = core_result;
          state_d     = StResp;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      rr_ptr_q      <= '0;
      key_cached_q  <= 1'b0;
      cached_addr_q <= '0;
      cur_addr_q    <= '0;
      cur_id_q      <= '0;
      block_q       <= '0;
      rom_en_q      <= 1'b0;
      core_init_q   <= 1'b0;
      core_next_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_id_q      <= '0;
      rsp_data_q    <= '0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      key_cached_q  <= key_cached_d;
      cached_addr_q <= cached_addr_d;
      cur_addr_q    <= cur_addr_d;
      cur_id_q      <= cur_id_d;
      block_q       <= block_d;
      rom_en_q      <= rom_en_d;
      core_init_q   <= core_init_d;
      core_next_q   <= core_next_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_id_q      <= rsp_id_d;
      rsp_data_q    <= rsp_data_d;
    end
  end

  assign rom_en     = rom_en_q;
  assign rom_addr   = cur_addr_q;
  assign core_init  = core_init_q;
  assign core_next  = core_next_q;
  assign core_block = block_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_data   = rsp_data_q;

endmodule

// File: tb/tb_aes_req_sched.sv
// Bench for aes_req_sched: ROM and AES core behavioural stand-ins, a transaction-level
// scoreboard (round-robin order, key-cache hit/miss, ciphertext), directed and random traffic.
module tb_aes_req_sched;
  localparam int NR = 4;
  localparam int AL = 128;
  localparam int AW = 5;
  localparam int IW = 2;
  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR*AW-1:0]  req_key_addr;
  logic [NR*AL-1:0]  req_block;
  logic              rom_en;
  logic [AW-1:0]     rom_addr;
  logic              core_init;
  logic              core_next;
  logic [AL-1:0]     core_block;
  logic              core_ready;
  logic              core_result_valid;
  logic [AL-1:0]     core_result;
  logic              rsp_valid;
  logic [IW-1:0]     rsp_id;
  logic [AL-1:0]     rsp_data;
  logic              rsp_ready;

  logic [AW-1:0]     addr_r [NR];
  logic [AL-1:0]     blk_r  [NR];

  always #5 clk = ~clk;

  for (genvar i = 0; i < NR; i++) begin : g_pack
    assign req_key_addr[i*AW +: AW] = addr_r[i];
    assign req_block[i*AL +: AL]    = blk_r[i];
  end

  aes_req_sched #(.NUM_REQ(NR), .AES_LEN(AL), .ADDR_WIDTH(AW), .ID_WIDTH(IW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_key_addr(req_key_addr), .req_block(req_block), .rom_en(rom_en), .rom_addr(rom_addr),
    .core_init(core_init), .core_next(core_next), .core_block(core_block),
    .core_ready(core_ready), .core_result_valid(core_result_valid), .core_result(core_result),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_ready(rsp_ready)
  );

  function automatic logic [127:0] rom_key(input logic [AW-1:0] a);
    if (a == 5'd3) return FIPS_KEY;
    return {4{32'h9e37_79b9 * (32'(a) + 32'd1)}} ^ {123'd0, a};
  endfunction

  // Stand-in cipher: exact for the FIPS-197 vector, otherwise any key-dependent mix.
  function automatic logic [127:0] cipher(input logic [127:0] k, input logic [127:0] b);
    if (k == FIPS_KEY && b == FIPS_PT) return FIPS_CT;
    return {b[62:0], b[127:63]} ^ k ^ 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;
  endfunction

  // Key ROM and core models. Latency = cycles from pulse until core_ready returns.
  logic [127:0] rom_dout, core_key;
  int           busy, klat, blat;
  logic         blk_pend;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rom_dout          <= '0;
      core_key          <= '0;
      busy              <= 0;
      blk_pend          <= 1'b0;
      core_result       <= '0;
      core_result_valid <= 1'b0;
    end else begin
      if (rom_en) rom_dout <= rom_key(rom_addr);
      if (core_init) begin
        core_key          <= rom_dout;
        busy              <= klat - 1;
        blk_pend          <= 1'b0;
        core_result_valid <= 1'b0;
      end else if (core_next) begin
        core_result       <= cipher(core_key, core_block);
        busy              <= blat - 1;
        blk_pend          <= 1'b1;
        core_result_valid <= 1'b0;
      end else if (busy != 0) begin
        busy <= busy - 1;
        if (busy == 1 && blk_pend) core_result_valid <= 1'b1;
      end
    end
  end
  assign core_ready = (busy == 0);

  int checks = 0;
  int failures = 0;
  int cyc = 0, n_rom = 0, n_init = 0, n_next = 0, n_gnt = 0, rsp_cnt = 0, exp_loads = 0;
  int acc_cyc = 0, rise_cyc = 0, hs_cyc = 0;
  int m_ptr = 0;
  logic m_cached = 1'b0, m_busy = 1'b0, rv_prev = 1'b0, hold_prev = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [IW-1:0] p_id = '0, last_id = '0;
  logic [127:0] p_data = '0, last_data = '0;
  int exp_id_q[$];
  logic [127:0] exp_data_q[$];
  int gnt_log[$];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_rom_en"}, rom_en, 0);
    chk({tag, "_rom_addr"}, rom_addr, 0);
    chk({tag, "_core_init"}, core_init, 0);
    chk({tag, "_core_next"}, core_next, 0);
    chk({tag, "_core_block"}, core_block, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_id"}, rsp_id, 0);
    chk({tag, "_rsp_data"}, rsp_data, 0);
  endtask

  // Transaction-level reference, sampled mid-cycle on the falling edge.
  task automatic monitor();
    int g, e, c;
    if (rst) begin
      m_ptr = 0; m_cached = 1'b0; m_busy = 1'b0; rv_prev = 1'b0; hold_prev = 1'b0;
      exp_id_q.delete(); exp_data_q.delete(); n_gnt = rsp_cnt;
      return;
    end
    cyc++;
    if (rom_en) n_rom++;
    if (core_init) n_init++;
    if (core_next) n_next++;
    if (hold_prev) begin
      chk("rsp_hold_valid", rsp_valid, 1);
      chk("rsp_hold_id", rsp_id, p_id);
      chk("rsp_hold_data", rsp_data, p_data);
    end
    if (req_ready != 0) begin
      chk("req_ready_onehot", $onehot(req_ready), 1);
      chk("grant_while_busy", m_busy, 0);
      g = 0;
      for (int i = 0; i < NR; i++) if (req_ready[i]) g = i;
      e = -1;
      for (int k = 0; k < NR; k++) begin
        c = (m_ptr + k) % NR;
        if (e < 0 && req_valid[c]) e = c;
      end
      chk("rr_grant", g, e);
      m_ptr = (g + 1) % NR;
      if (!(m_cached && addr_r[g] == m_addr)) exp_loads++;
      m_cached = 1'b1;
      m_addr = addr_r[g];
      exp_id_q.push_back(g);
      exp_data_q.push_back(cipher(rom_key(addr_r[g]), blk_r[g]));
      gnt_log.push_back(g);
      acc_cyc = cyc;
      n_gnt++;
      m_busy = 1'b1;
    end
    if (rsp_valid && !rv_prev) rise_cyc = cyc;
    if (rsp_valid && rsp_ready) begin
      chk("rsp_expected", exp_id_q.size() != 0, 1);
      if (exp_id_q.size() != 0) begin
        chk("rsp_id", rsp_id, exp_id_q.pop_front());
        chk("rsp_data", rsp_data, exp_data_q.pop_front());
      end
      last_id = rsp_id; last_data = rsp_data; hs_cyc = cyc;
      rsp_cnt++;
      m_busy = 1'b0;
    end
    hold_prev = rsp_valid && !rsp_ready;
    p_id = rsp_id; p_data = rsp_data; rv_prev = rsp_valid;
  endtask

  // One clock: observe on the falling edge, then retire accepted requests after the rising edge.
  task automatic tick();
    logic [NR-1:0] acc;
    @(negedge clk);
    monitor();
    acc = req_ready;
    @(posedge clk);
    #1;
    req_valid = req_valid & ~acc;
  endtask

  task automatic issue(input int r, input logic [AW-1:0] a, input logic [127:0] b);
    addr_r[r] = a;
    blk_r[r] = b;
    req_valid[r] = 1'b1;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int t = 0;
    while ((req_valid != 0 || rsp_cnt < n_gnt) && t < budget) begin
      tick();
      t++;
    end
    chk(tag, rsp_cnt, n_gnt);
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  initial begin
    int b_rom, b_init, b_next, b_gnt, b_loads, b_rsp;
    rst = 1'b1; req_valid = '0; rsp_ready = 1'b0; klat = 5; blat = 7;
    for (int i = 0; i < NR; i++) begin addr_r[i] = '0; blk_r[i] = '0; end
    repeat (3) tick();
    issue(1, 5'd9, rnd128());
    #1;
    chk_zero("reset");
    req_valid = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk_zero("post_reset");

    // FIPS-197 vector from requester 0 (key miss)
    rsp_ready = 1'b1;
    b_rom = n_rom; b_init = n_init; b_next = n_next;
    issue(0, 5'd3, FIPS_PT);
    wait_idle("t1_done", 200);
    chk("t1_data", last_data, FIPS_CT);
    chk("t1_id", last_id, 0);
    chk("t1_rom_en", n_rom - b_rom, 1);
    chk("t1_init", n_init - b_init, 1);
    chk("t1_next", n_next - b_next, 1);
    chk("t1_miss_latency", rise_cyc - acc_cyc, 3 + klat + blat + 1);

    // Same key again: cache hit
    b_rom = n_rom; b_init = n_init;
    issue(0, 5'd3, rnd128());
    wait_idle("t2_done", 200);
    chk("t2_rom_en", n_rom - b_rom, 0);
    chk("t2_init", n_init - b_init, 0);
    chk("t2_hit_latency", rise_cyc - acc_cyc, 1 + blat + 1);
    issue(3, 5'd3, rnd128());
    wait_idle("t2b_done", 200);

    // All requesters held pending: grants 0,1,2,3,0
    gnt_log.delete();
    for (int i = 0; i < NR; i++) issue(i, 5'd3, rnd128());
    for (int t = 0; t < 400 && gnt_log.size() < 5; t++) begin
      tick();
      for (int i = 0; i < NR; i++) if (!req_valid[i] && gnt_log.size() < 5) issue(i, 5'd3, rnd128());
    end
    req_valid = '0;
    chk("t3_grant_count", gnt_log.size(), 5);
    for (int k = 0; k < 5 && k < gnt_log.size(); k++) chk("t3_grant_order", gnt_log[k], k % NR);
    wait_idle("t3_done", 300);

    // Alternating keys 7/3: every request reloads
    b_rom = n_rom; b_init = n_init;
    for (int k = 0; k < 4; k++) begin
      issue(1 + (k % 2), (k % 2 == 0) ? 5'd7 : 5'd3, rnd128());
      wait_idle("t4_done", 200);
    end
    chk("t4_rom_en", n_rom - b_rom, 4);
    chk("t4_init", n_init - b_init, 4);

    // Response backpressure
    rsp_ready = 1'b0;
    issue(2, 5'd3, rnd128());
    for (int t = 0; t < 100 && !rsp_valid; t++) tick();
    chk("t5_rsp_valid", rsp_valid, 1);
    issue(1, 5'd7, rnd128());
    b_gnt = n_gnt;
    repeat (10) tick();
    chk("t5_no_grant", n_gnt - b_gnt, 0);
    chk("t5_still_valid", rsp_valid, 1);
    rsp_ready = 1'b1;
    b_rsp = rsp_cnt;
    for (int t = 0; t < 5 && rsp_cnt == b_rsp; t++) tick();
    chk("t5_rsp_drop", rsp_valid, 0);
    for (int t = 0; t < 5 && n_gnt == b_gnt; t++) tick();
    chk("t5_regrant_gap", acc_cyc - hs_cyc, 1);
    wait_idle("t5_done", 200);

    // Reset during key expansion invalidates the cache
    klat = 20;
    b_init = n_init;
    issue(0, 5'd5, rnd128());
    for (int t = 0; t < 20 && n_init == b_init; t++) tick();
    repeat (2) tick();
    rst = 1'b1;
    issue(2, 5'd3, rnd128());
    #1;
    chk_zero("mid_reset");
    repeat (2) tick();
    req_valid = '0;
    rst = 1'b0;
    klat = 5;
    b_rom = n_rom; b_init = n_init;
    issue(0, 5'd5, rnd128());
    wait_idle("t6_done", 200);
    chk("t6_reload_rom", n_rom - b_rom, 1);
    chk("t6_reload_init", n_init - b_init, 1);

    // Random traffic
    b_rom = n_rom; b_init = n_init; b_next = n_next; b_gnt = n_gnt; b_loads = exp_loads;
    for (int t = 0; t < 1500; t++) begin
      klat = $urandom_range(2, 8);
      blat = $urandom_range(2, 8);
      rsp_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NR; i++) begin
        if (!req_valid[i] && $urandom_range(0, 3) == 0)
          issue(i, 5'(2 * $urandom_range(0, 3) + 1), rnd128());
        else if (req_valid[i] && $urandom_range(0, 19) == 0)
          req_valid[i] = 1'b0;
      end
      tick();
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    wait_idle("rand_drain", 300);
    chk("rand_rom_en", n_rom - b_rom, exp_loads - b_loads);
    chk("rand_init", n_init - b_init, exp_loads - b_loads);
    chk("rand_next", n_next - b_next, n_gnt - b_gnt);
    chk("rand_activity", (n_gnt - b_gnt) > 20, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
